// File: rtl/dac_sample_pacer_pkg.sv
// Shared types and constants for the DAC sample pacer.
package dac_sample_pacer_pkg;

  localparam int unsigned SAMPLE_W = 10;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t MIDSCALE_DEF = 10'h200;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } pacer_state_e;

  // Saturating increment for the 8-bit event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dac_sample_pacer_if.sv
// Producer write port plus DAC-side load/chip-select signals.
interface dac_sample_pacer_if;
  import dac_sample_pacer_pkg::*;

  sample_t wr_data;
  logic    wr_valid;
  logic    wr_ready;
  logic    dac_cs;
  sample_t data_out;
  logic    load;

  // Sources of samples and chip-select (producer and DAC SPI block).
  modport master (
    output wr_data, wr_valid, dac_cs,
    input  wr_ready, data_out, load
  );

  // The pacer itself.
  modport slave (
    input  wr_data, wr_valid, dac_cs,
    output wr_ready, data_out, load
  );
endinterface

// File: rtl/dac_sample_pacer_sync_fifo.sv
// Single-clock FIFO with registered occupancy and first-word-fall-through head.
module dac_sample_pacer_sync_fifo #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap modulo depth; level tracks net push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_ok) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Buffers producer samples and releases one per sample tick to the DAC SPI block,
// never issuing a load while a chip-select frame is outstanding.
module dac_sample_pacer
  import dac_sample_pacer_pkg::*;
#(
  parameter int unsigned DIV        = 1000,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned CS_TIMEOUT = 2047,
  parameter sample_t     MIDSCALE   = MIDSCALE_DEF
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 enable,
  dac_sample_pacer_if.slave    bus,
  output logic [DEPTH_LOG2:0]  fifo_level,
  output logic [7:0]           underrun_cnt,
  output logic [7:0]           overrun_cnt,
  output logic                 cs_timeout
);

  localparam int unsigned TICK_W = 16;
  localparam int unsigned TO_W   = $clog2(CS_TIMEOUT + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              cs_meta;
  logic              cs_sync;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  sample_t           fifo_head;

  pacer_state_e      state;
  pacer_state_e      state_next;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_next;
  logic              load_next;
  sample_t           data_next;
  logic [7:0]        under_next;
  logic [7:0]        over_next;
  logic              timeout_next;

  assign tick = enable && (tick_cnt == TICK_W'(DIV - 1));

  // Sample-rate divider; parked at zero while disabled.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Two-flop synchroniser for chip-select; idles high (no frame).
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= bus.dac_cs;
      cs_sync <= cs_meta;
    end
  end

  assign bus.wr_ready = !fifo_full;
  assign fifo_rd      = (state == ST_LOAD);

  dac_sample_pacer_sync_fifo #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (sysclk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_valid && bus.wr_ready),
    .wr_data (bus.wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State and registered outputs; load/data_out are set on entry to LOAD.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      to_cnt       <= '0;
      bus.load     <= 1'b0;
      bus.data_out <= MIDSCALE;
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
      cs_timeout   <= 1'b0;
    end else begin
      state        <= state_next;
      to_cnt       <= to_cnt_next;
      bus.load     <= load_next;
      bus.data_out <= data_next;
      underrun_cnt <= under_next;
      overrun_cnt  <= over_next;
      cs_timeout   <= timeout_next;
    end
  end

  // Next-state: tick dispatch, chip-select handshake and its timeout.
  always_comb begin
    state_next   = state;
    to_cnt_next  = to_cnt;
    load_next    = 1'b0;
    data_next    = bus.data_out;
    under_next   = underrun_cnt;
    over_next    = overrun_cnt;
    timeout_next = cs_timeout;

    if (tick && (state != ST_IDLE)) over_next = sat_inc8(overrun_cnt);

    case (state)
      ST_IDLE: begin
        if (tick) begin
          if (!fifo_empty) begin
            state_next = ST_LOAD;
            load_next  = 1'b1;
            data_next  = fifo_head;
          end else begin
            under_next = sat_inc8(underrun_cnt);
          end
        end
      end
      ST_LOAD: begin
        state_next  = ST_WAIT_LOW;
        to_cnt_next = '0;
      end
      ST_WAIT_LOW: begin
        if (!cs_sync) begin
          state_next = ST_WAIT_HIGH;
        end else if (to_cnt == TO_W'(CS_TIMEOUT - 1)) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b1;
        end else begin
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end
      ST_WAIT_HIGH: begin
        if (cs_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Self-checking bench for dac_sample_pacer with a queue-based sample model and a DAC chip-select model.
module tb_dac_sample_pacer;
  import dac_sample_pacer_pkg::*;

  localparam int unsigned DIV        = 1000;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned CS_TIMEOUT = 100;
  localparam int unsigned DEPTH      = 16;

  typedef struct {
    int unsigned at;
    sample_t     data;
  } ld_t;

  logic              sysclk = 1'b0;
  logic              rst_n  = 1'b0;
  logic              enable = 1'b0;
  logic [DEPTH_LOG2:0] fifo_level;
  logic [7:0]        underrun_cnt;
  logic [7:0]        overrun_cnt;
  logic              cs_timeout;

  logic    wr_valid_drv = 1'b0;
  sample_t wr_data_drv  = '0;
  logic    dac_cs_drv   = 1'b1;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned cyc          = 0;
  sample_t     exp_q [$];
  ld_t         load_q [$];
  int          exp_under = 0;
  int          exp_over  = 0;
  bit          push_on   = 1'b0;
  bit          cs_stuck  = 1'b0;
  int          cs_low_delay = 40;
  int          cs_low_len   = 900;
  int          cs_phase = 0;
  int          cs_cnt   = 0;

  dac_sample_pacer_if bus ();

  assign bus.wr_valid = wr_valid_drv;
  assign bus.wr_data  = wr_data_drv;
  assign bus.dac_cs   = dac_cs_drv;

  dac_sample_pacer #(
    .DIV        (DIV),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CS_TIMEOUT (CS_TIMEOUT),
    .MIDSCALE   (10'h200)
  ) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .enable       (enable),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt),
    .cs_timeout   (cs_timeout)
  );

  always #10 sysclk = ~sysclk;

  // Cycle stamp and load recorder; a load seen at posedge N+1 belongs to cycle N.
  always @(posedge sysclk) begin
    if (rst_n && bus.load) load_q.push_back('{at: cyc, data: bus.data_out});
    cyc = cyc + 1;
  end

  // DAC SPI block model: drop cs some cycles after a load, hold it low, raise it.
  always @(negedge sysclk) begin
    if (!rst_n) begin
      cs_phase   = 0;
      dac_cs_drv = 1'b1;
    end else begin
      case (cs_phase)
        0: if (bus.load && !cs_stuck) begin cs_phase = 1; cs_cnt = cs_low_delay; end
        1: begin
          cs_cnt--;
          if (cs_cnt <= 0) begin dac_cs_drv = 1'b0; cs_phase = 2; cs_cnt = cs_low_len; end
        end
        default: begin
          cs_cnt--;
          if (cs_cnt <= 0) begin dac_cs_drv = 1'b1; cs_phase = 0; end
        end
      endcase
    end
  end

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle; optionally offers a random sample and records it if accepted.
  task automatic step();
    @(negedge sysclk);
    if (push_on) begin
      wr_valid_drv = 1'b1;
      wr_data_drv  = 10'($urandom);
      if (bus.wr_ready && rst_n) exp_q.push_back(wr_data_drv);
    end else begin
      wr_valid_drv = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_sample(input sample_t d);
    @(negedge sysclk);
    wr_valid_drv = 1'b1;
    wr_data_drv  = d;
    if (bus.wr_ready) exp_q.push_back(d);
    @(negedge sysclk);
    wr_valid_drv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (3) @(negedge sysclk);
    tests_run++; if (bus.wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready got=%b exp=1", bus.wr_ready); end
    tests_run++; if (bus.data_out !== 10'h200) begin tests_failed++; $display("FAIL reset_data_out got=%h exp=200", bus.data_out); end
    tests_run++; if (bus.load !== 1'b0) begin tests_failed++; $display("FAIL reset_load got=%b exp=0", bus.load); end
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    tests_run++; if (underrun_cnt !== 8'd0 || overrun_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", underrun_cnt, overrun_cnt); end
    tests_run++; if (cs_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_cs_timeout got=%b exp=0", cs_timeout); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_underrun();
    load_q.delete();
    enable = 1'b1;
    run(int'(DIV) - 1);
    tests_run++; if (underrun_cnt !== 8'(exp_under)) begin tests_failed++; $display("FAIL underrun_before_first_tick got=%0d exp=%0d", underrun_cnt, exp_under); end
    run(1);
    exp_under += 1;
    tests_run++; if (underrun_cnt !== 8'(exp_under)) begin tests_failed++; $display("FAIL underrun_first_tick got=%0d exp=%0d", underrun_cnt, exp_under); end
    run(4 * int'(DIV));
    exp_under += 4;
    enable = 1'b0;
    tests_run++; if (underrun_cnt !== 8'(exp_under)) begin tests_failed++; $display("FAIL underrun_five_ticks got=%0d exp=%0d", underrun_cnt, exp_under); end
    tests_run++; if (load_q.size() != 0) begin tests_failed++; $display("FAIL underrun_no_load got=%0d loads exp=0", load_q.size()); end
    tests_run++; if (bus.data_out !== 10'h200) begin tests_failed++; $display("FAIL underrun_data_held got=%h exp=200", bus.data_out); end
    step();
  endtask

  task automatic test_stream();
    sample_t     pat [3];
    sample_t     ex;
    int unsigned e;
    int          n_exp;
    pat[0] = 10'h001; pat[1] = 10'h155; pat[2] = 10'h3FF;
    for (int i = 0; i < 3; i++) push_sample(pat[i]);
    tests_run++; if (fifo_level !== 5'd3) begin tests_failed++; $display("FAIL stream_level_pre got=%0d exp=3", fifo_level); end
    cs_stuck = 1'b0; cs_low_delay = 40; cs_low_len = 900;
    load_q.delete();
    n_exp = exp_q.size();
    e = cyc; enable = 1'b1;
    run(5 * int'(DIV) + 5);
    enable = 1'b0;
    exp_under += 5 - n_exp;
    tests_run++; if (load_q.size() != n_exp) begin tests_failed++; $display("FAIL stream_load_count got=%0d exp=%0d", load_q.size(), n_exp); end
    for (int k = 0; k < n_exp; k++) begin
      ex = exp_q.pop_front();
      if (k < load_q.size()) begin
        tests_run++; if (load_q[k].data !== ex) begin tests_failed++; $display("FAIL stream_data[%0d] got=%h exp=%h", k, load_q[k].data, ex); end
        tests_run++; if (load_q[k].at != e + DIV * (k + 1)) begin tests_failed++; $display("FAIL stream_time[%0d] got=%0d exp=%0d", k, load_q[k].at - e, DIV * (k + 1)); end
      end
    end
    tests_run++; if (bus.data_out !== pat[2]) begin tests_failed++; $display("FAIL stream_data_held got=%h exp=%h", bus.data_out, pat[2]); end
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL stream_level_post got=%0d exp=0", fifo_level); end
    tests_run++; if (underrun_cnt !== 8'(exp_under)) begin tests_failed++; $display("FAIL stream_underrun got=%0d exp=%0d", underrun_cnt, exp_under); end
    tests_run++; if (overrun_cnt !== 8'(exp_over) || cs_timeout !== 1'b0) begin tests_failed++; $display("FAIL stream_overrun_timeout got=%0d/%b exp=%0d/0", overrun_cnt, cs_timeout, exp_over); end
    step();
  endtask

  task automatic test_fill();
    sample_t     ex;
    int unsigned e;
    push_on = 1'b1;
    run(20);
    tests_run++; if (fifo_level !== 5'(DEPTH)) begin tests_failed++; $display("FAIL fill_level got=%0d exp=%0d", fifo_level, DEPTH); end
    tests_run++; if (bus.wr_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_wr_ready got=%b exp=0", bus.wr_ready); end
    load_q.delete();
    e = cyc; enable = 1'b1;
    run(int'(DIV) + 5);
    enable = 1'b0; push_on = 1'b0;
    tests_run++; if (load_q.size() != 1) begin tests_failed++; $display("FAIL fill_load_count got=%0d exp=1", load_q.size()); end
    ex = exp_q.pop_front();
    if (load_q.size() > 0) begin
      tests_run++; if (load_q[0].data !== ex || load_q[0].at != e + DIV) begin tests_failed++; $display("FAIL fill_load got=%h@%0d exp=%h@%0d", load_q[0].data, load_q[0].at - e, ex, DIV); end
    end
    tests_run++; if (fifo_level !== 5'(DEPTH)) begin tests_failed++; $display("FAIL fill_level_refill got=%0d exp=%0d", fifo_level, DEPTH); end
    run(int'(DIV));
  endtask

  task automatic test_overrun();
    sample_t     ex;
    int unsigned e;
    cs_low_delay = 40; cs_low_len = 1200;
    load_q.delete();
    e = cyc; enable = 1'b1;
    run(3 * int'(DIV) + 5);
    enable = 1'b0;
    exp_over += 1;
    tests_run++; if (overrun_cnt !== 8'(exp_over)) begin tests_failed++; $display("FAIL overrun_count got=%0d exp=%0d", overrun_cnt, exp_over); end
    tests_run++; if (underrun_cnt !== 8'(exp_under)) begin tests_failed++; $display("FAIL overrun_underrun got=%0d exp=%0d", underrun_cnt, exp_under); end
    tests_run++; if (load_q.size() != 2) begin tests_failed++; $display("FAIL overrun_load_count got=%0d exp=2", load_q.size()); end
    for (int k = 0; k < 2; k++) begin
      ex = exp_q.pop_front();
      if (k < load_q.size()) begin
        tests_run++; if (load_q[k].data !== ex) begin tests_failed++; $display("FAIL overrun_data[%0d] got=%h exp=%h", k, load_q[k].data, ex); end
        tests_run++; if (load_q[k].at != e + DIV * (2 * k + 1)) begin tests_failed++; $display("FAIL overrun_time[%0d] got=%0d exp=%0d", k, load_q[k].at - e, DIV * (2 * k + 1)); end
      end
    end
    run(1300);
    cs_low_len = 900;
  endtask

  task automatic test_timeout();
    sample_t     ex;
    int unsigned e;
    cs_stuck = 1'b1;
    load_q.delete();
    e = cyc; enable = 1'b1;
    for (int i = 1; i <= 2 * int'(DIV) + 5; i++) begin
      step();
      if (i == int'(DIV + CS_TIMEOUT) - 3) begin
        tests_run++; if (cs_timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_early got=%b exp=0", cs_timeout); end
      end
      if (i == int'(DIV + CS_TIMEOUT) + 3) begin
        tests_run++; if (cs_timeout !== 1'b1) begin tests_failed++; $display("FAIL timeout_set got=%b exp=1", cs_timeout); end
      end
    end
    enable = 1'b0;
    tests_run++; if (load_q.size() != 2) begin tests_failed++; $display("FAIL timeout_load_count got=%0d exp=2", load_q.size()); end
    for (int k = 0; k < 2; k++) begin
      ex = exp_q.pop_front();
      if (k < load_q.size()) begin
        tests_run++; if (load_q[k].data !== ex || load_q[k].at != e + DIV * (k + 1)) begin tests_failed++; $display("FAIL timeout_load[%0d] got=%h@%0d exp=%h@%0d", k, load_q[k].data, load_q[k].at - e, ex, DIV * (k + 1)); end
      end
    end
    run(200);
    tests_run++; if (cs_timeout !== 1'b1 || overrun_cnt !== 8'(exp_over)) begin tests_failed++; $display("FAIL timeout_sticky got=%b/%0d exp=1/%0d", cs_timeout, overrun_cnt, exp_over); end
    cs_stuck = 1'b0;
  endtask

  task automatic test_random();
    sample_t     ex;
    int unsigned e;
    int          n_push;
    int          n_tick;
    int          n_load;
    for (int r = 0; r < 4; r++) begin
      n_push = int'($urandom_range(0, 6));
      for (int j = 0; j < n_push; j++) push_sample(10'($urandom));
      tests_run++; if (int'(fifo_level) != exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_level_pre got=%0d exp=%0d", r, fifo_level, exp_q.size()); end
      cs_low_delay = int'($urandom_range(5, 90));
      cs_low_len   = int'($urandom_range(10, 800));
      n_tick = int'($urandom_range(1, 5));
      n_load = (n_tick < exp_q.size()) ? n_tick : exp_q.size();
      exp_under += n_tick - n_load;
      if (exp_under > 255) exp_under = 255;
      load_q.delete();
      e = cyc; enable = 1'b1;
      run(n_tick * int'(DIV) + 3);
      enable = 1'b0;
      tests_run++; if (load_q.size() != n_load) begin tests_failed++; $display("FAIL rand%0d_load_count got=%0d exp=%0d", r, load_q.size(), n_load); end
      for (int k = 0; k < n_load; k++) begin
        ex = exp_q.pop_front();
        if (k < load_q.size()) begin
          tests_run++; if (load_q[k].data !== ex || load_q[k].at != e + DIV * (k + 1)) begin tests_failed++; $display("FAIL rand%0d_load[%0d] got=%h@%0d exp=%h@%0d", r, k, load_q[k].data, load_q[k].at - e, ex, DIV * (k + 1)); end
        end
      end
      tests_run++; if (underrun_cnt !== 8'(exp_under) || overrun_cnt !== 8'(exp_over)) begin tests_failed++; $display("FAIL rand%0d_counters got=%0d/%0d exp=%0d/%0d", r, underrun_cnt, overrun_cnt, exp_under, exp_over); end
      tests_run++; if (int'(fifo_level) != exp_q.size()) begin tests_failed++; $display("FAIL rand%0d_level_post got=%0d exp=%0d", r, fifo_level, exp_q.size()); end
      run(1000);
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 6; j++) push_sample(10'($urandom));
    cs_low_delay = 40; cs_low_len = 900;
    enable = 1'b1;
    run(int'(DIV) + 100);
    tests_run++; if (fifo_level < 5'd5) begin tests_failed++; $display("FAIL rstmid_level_pre got=%0d exp>=5", fifo_level); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (fifo_level !== 5'd0 || bus.wr_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_fifo got=%0d/%b exp=0/1", fifo_level, bus.wr_ready); end
    tests_run++; if (bus.data_out !== 10'h200 || bus.load !== 1'b0) begin tests_failed++; $display("FAIL rstmid_dac got=%h/%b exp=200/0", bus.data_out, bus.load); end
    tests_run++; if (underrun_cnt !== 8'd0 || overrun_cnt !== 8'd0 || cs_timeout !== 1'b0) begin tests_failed++; $display("FAIL rstmid_status got=%0d/%0d/%b exp=0/0/0", underrun_cnt, overrun_cnt, cs_timeout); end
    enable = 1'b0;
    exp_q.delete();
    exp_under = 0; exp_over = 0;
    @(negedge sysclk);
    rst_n = 1'b1;
    step();
    load_q.delete();
    enable = 1'b1;
    run(int'(DIV) + 2);
    enable = 1'b0;
    exp_under += 1;
    tests_run++; if (load_q.size() != 0 || underrun_cnt !== 8'(exp_under)) begin tests_failed++; $display("FAIL rstmid_discard got=%0d loads/%0d underrun exp=0/%0d", load_q.size(), underrun_cnt, exp_under); end
    step();
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_stream();
    test_fill();
    test_overrun();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
- Upstream feeder for the SPI DAC interface: buffers 10-bit samples from a producer (waveform generator, ROM, ADC loopback) in a small FIFO.
- Releases one sample per sample-rate tick as a held data word plus a one-cycle load pulse.
- Interlocks on the DAC chip-select so a new load is never issued mid-frame.
- Sits between sample sources and the DAC SPI block, on the 50 MHz system clock.

Parameters:
- DIV, 1000, sysclk cycles per sample tick (1000 = 50 kHz); legal range 64..65535.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries.
- CS_TIMEOUT, 2047, sysclk cycles to wait for dac_cs to fall after load before abandoning the frame.
- MIDSCALE, 10'h200, data_out value at reset.

Ports:
- sysclk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = run tick counter and issue loads; 0 = tick counter held at 0, FSM finishes any frame then idles
- wr_data  in  10  sample from producer
- wr_valid  in  1  producer has a sample
- wr_ready  out  1  FIFO not full
- dac_cs  in  1  chip-select from DAC SPI block (low = frame in progress)
- data_out  out  10  sample to DAC block, held stable between loads
- load  out  1  one-sysclk pulse requesting a DAC write
- fifo_level  out  DEPTH_LOG2+1  current occupancy
- underrun_cnt  out  8  saturating count of ticks with an empty FIFO
- overrun_cnt  out  8  saturating count of ticks arriving while a frame is outstanding
- cs_timeout  out  1  sticky; set when the CS_TIMEOUT wait expires

Behaviour:
- Interface: one clock (sysclk); reset rst_n is asynchronous and active-low.
- Reset values: wr_ready=1, data_out=MIDSCALE, load=0, fifo_level=0, both counters=0, cs_timeout=0, tick counter=0, FSM=IDLE.
- Reset mid-frame aborts the frame immediately. FIFO contents are discarded.
- FIFO:
  - Write occurs when wr_valid && wr_ready.
  - Read occurs only in the LOAD state.
  - Simultaneous read and write when full is allowed: level stays the same. wr_ready depends on registered level only.
  - Pointers wrap modulo depth. Level is 0..2**DEPTH_LOG2.
- Tick:
  - Counter runs 0..DIV-1 while enable=1.
  - tick is asserted for one cycle when the counter equals DIV-1. The first tick comes DIV cycles after enable rises.
- FSM states:
  - IDLE: on tick with FIFO non-empty -> LOAD. On tick with FIFO empty -> increment underrun_cnt (saturate at 255), stay IDLE; data_out holds its last value.
  - LOAD (1 cycle): pop FIFO head into data_out, assert load=1 on the same cycle, -> WAIT_LOW.
  - WAIT_LOW: stay until dac_cs==0, then -> WAIT_HIGH. A timeout counter starts on entry. If it reaches CS_TIMEOUT: set cs_timeout, -> IDLE.
  - WAIT_HIGH: stay until dac_cs==1, then -> IDLE.
- Timing: load is high exactly one cycle per accepted tick. Latency from tick to load is 1 cycle. data_out changes only in the LOAD cycle.
- A tick in LOAD/WAIT_LOW/WAIT_HIGH increments overrun_cnt (saturating). The sample is not consumed.
- dac_cs is asynchronous to the DAC's derived clock domain: pass it through a 2-flop synchroniser before FSM use.
- enable low: no new LOADs. An in-progress frame completes normally.

Decomposition:
- Shared package: FSM state encoding (IDLE, LOAD, WAIT_LOW, WAIT_HIGH), sample width constant 10, MIDSCALE constant.
- One natural sub-module: sync_fifo (parameterised width/depth, registered level, full/empty).

Test Plan:
- Reset with enable=1 and no writes, 5 ticks (DIV=64) -> load never asserted, data_out=10'h200, underrun_cnt=5.
- Write 3 samples 10'h001/10'h155/10'h3FF, model DAC drops cs 40 cycles after load and raises it 900 cycles later, DIV=1000 -> three loads spaced exactly 1000 cycles apart, data_out sequence 001,155,3FF, fifo_level 3->0, then underrun_cnt increments on each further tick.
- Hold wr_valid=1 with enable=0 -> wr_ready drops after 16 writes, fifo_level=16. Then pop and push on the same cycle -> level stays 16.
- DAC model holds cs low for 1200 cycles with DIV=1000 -> overrun_cnt=1, next load only after cs high plus a tick.
- dac_cs stuck high with CS_TIMEOUT=100 -> cs_timeout set 100 cycles after load (plus synchroniser delay), FSM returns to IDLE, next tick loads the next sample.
- Assert rst_n low in WAIT_HIGH with 5 samples queued -> all outputs return to reset values asynchronously, fifo_level=0.
